// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction/function codes,
// CC bit positions, FSM states and the branch/cmov condition evaluator.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] C_ALW = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_XOR} alu_op_e;

  // Returns {illegal, taken}; illegal condition codes are never taken.
  function automatic logic [1:0] eval_cond(input logic [2:0] cc, input logic [3:0] ifun);
    logic zf, sf, of;
    zf = cc[CC_ZF];
    sf = cc[CC_SF];
    of = cc[CC_OF];
    case (ifun)
      C_ALW:   return 2'b01;
      C_LE:    return {1'b0, (sf ^ of) | zf};
      C_L:     return {1'b0, sf ^ of};
      C_E:     return {1'b0, zf};
      C_NE:    return {1'b0, ~zf};
      C_GE:    return {1'b0, ~(sf ^ of)};
      C_G:     return {1'b0, ~(sf ^ of) & ~zf};
      default: return 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/execute_alu_ctrl_if.sv
// Decode-side request and memory-side result bundle of the execute stage.
interface execute_alu_ctrl_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       icode;
  logic [3:0]       ifun;
  logic [WIDTH-1:0] val_a;
  logic [WIDTH-1:0] val_b;
  logic [WIDTH-1:0] val_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] val_e;
  logic             cnd;
  logic [2:0]       cc;
  logic             err;

  modport master (
    output in_valid, icode, ifun, val_a, val_b, val_c, out_ready,
    input  in_ready, out_valid, val_e, cnd, cc, err
  );

  modport slave (
    input  in_valid, icode, ifun, val_a, val_b, val_c, out_ready,
    output in_ready, out_valid, val_e, cnd, cc, err
  );
endinterface

// File: rtl/alu_core.sv
// Combinational Y86 ALU: computes B op A and the {ZF,SF,OF} flags that result.
module alu_core
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic [2:0]       flags_o
);

  logic of;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    result_o = '0;
    of       = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = b_i + a_i;
        of = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        result_o = b_i - a_i;
        of = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (result_o[WIDTH-1] != b_i[WIDTH-1]);
      end
      OP_AND:  result_o = b_i & a_i;
      OP_XOR:  result_o = b_i ^ a_i;
      default: result_o = '0;
    endcase
  end

  assign flags_o = {(result_o == '0), result_o[WIDTH-1], of};

endmodule

// File: rtl/execute_alu_ctrl.sv
// Y86-64 execute-stage sequencer: IDLE/EXEC/DONE handshake, ALU operand selection,
// condition-code register and registered valE/Cnd/err.
module execute_alu_ctrl
  import y86_pkg::*;
#(
  parameter int         WIDTH      = 64,
  parameter int         STACK_STEP = 8,
  parameter logic [2:0] CC_RESET   = 3'b100
) (
  input logic                clk,
  input logic                rst,
  execute_alu_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [3:0]       icode_q, ifun_q;
  logic [WIDTH-1:0] val_a_q, val_b_q, val_c_q;
  logic [WIDTH-1:0] val_e_q;
  logic             cnd_q, err_q;
  logic [2:0]       cc_q;

  alu_op_e          alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [2:0]       alu_flags;
  logic             cnd_d, err_d, set_cc;
  logic [1:0]       cond_r;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Conditions always see the CC held while in EXEC, i.e. before this op's own update.
  assign cond_r = eval_cond(cc_q, ifun_q);

  always_comb begin
    alu_op = OP_ADD;
    alu_a  = '0;
    alu_b  = '0;
    cnd_d  = 1'b1;
    err_d  = 1'b0;
    set_cc = 1'b0;
    case (icode_q)
      I_HALT, I_NOP: ;
      I_RRMOVQ: begin
        alu_a          = val_a_q;
        {err_d, cnd_d} = cond_r;
      end
      I_JXX:    {err_d, cnd_d} = cond_r;
      I_IRMOVQ: alu_a = val_c_q;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = val_c_q;
        alu_b = val_b_q;
      end
      I_CALL, I_PUSHQ: begin
        alu_op = OP_SUB;
        alu_a  = WIDTH'(STACK_STEP);
        alu_b  = val_b_q;
      end
      I_RET, I_POPQ: begin
        alu_a = WIDTH'(STACK_STEP);
        alu_b = val_b_q;
      end
      I_OPQ: begin
        if (ifun_q <= ALU_XOR) begin
          alu_op = alu_op_e'(ifun_q[1:0]);
          alu_a  = val_a_q;
          alu_b  = val_b_q;
          set_cc = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: err_d = 1'b1;
    endcase
  end

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_res),
    .flags_o  (alu_flags)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      val_e_q <= '0;
      cnd_q   <= 1'b0;
      err_q   <= 1'b0;
      cc_q    <= CC_RESET;
    end else begin
      state_q <= state_d;
      if (state_q == S_EXEC) begin
        val_e_q <= alu_res;
        cnd_q   <= cnd_d;
        err_q   <= err_d;
        if (set_cc) cc_q <= alu_flags;
      end
    end
  end

  // NOTE: the operand latches carry no reset; they are only read in EXEC, after a load.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.in_valid) begin
      icode_q <= bus.icode;
      ifun_q  <= bus.ifun;
      val_a_q <= bus.val_a;
      val_b_q <= bus.val_b;
      val_c_q <= bus.val_c;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.val_e     = val_e_q;
  assign bus.cnd       = cnd_q;
  assign bus.err       = err_q;
  assign bus.cc        = cc_q;

endmodule

// File: tb/tb_execute_alu_ctrl.sv
// Self-checking bench for execute_alu_ctrl: directed vector table, stall/reset sequences
// and randomized ops against a behavioural Y86 execute model.
module tb_execute_alu_ctrl;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
    logic [63:0] vale;
    logic        cnd;
    logic        err;
    logic [2:0]  cc;
  } vec_t;

  typedef struct {
    logic [63:0] vale;
    logic        cnd;
    logic        err;
    logic [2:0]  cc;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [2:0] model_cc;

  execute_alu_ctrl_if #(.WIDTH(64)) bus ();

  execute_alu_ctrl #(.WIDTH(64), .STACK_STEP(8), .CC_RESET(3'b100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] model_cond(input logic [3:0] ifn, input logic [2:0] cc);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    case (ifn)
      4'd0:    return 2'b01;
      4'd1:    return {1'b0, (sf != of) || zf};
      4'd2:    return {1'b0, sf != of};
      4'd3:    return {1'b0, zf};
      4'd4:    return {1'b0, !zf};
      4'd5:    return {1'b0, sf == of};
      4'd6:    return {1'b0, (sf == of) && !zf};
      default: return 2'b10;
    endcase
  endfunction

  // Signed overflow is taken from a 65-bit sign-extended sum: it overflowed if the top two bits differ.
  function automatic res_t model(input logic [3:0] ic, input logic [3:0] ifn,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] c, input logic [2:0] cc);
    res_t r;
    logic [64:0] w;
    logic of;
    r.vale = 64'd0;
    r.cnd  = 1'b1;
    r.err  = 1'b0;
    r.cc   = cc;
    of     = 1'b0;
    case (ic)
      4'h0, 4'h1: ;
      4'h2: begin r.vale = a; {r.err, r.cnd} = model_cond(ifn, cc); end
      4'h7: {r.err, r.cnd} = model_cond(ifn, cc);
      4'h3: r.vale = c;
      4'h4, 4'h5: r.vale = b + c;
      4'h8, 4'hA: r.vale = b - 64'd8;
      4'h9, 4'hB: r.vale = b + 64'd8;
      4'h6: begin
        if (ifn > 4'd3) begin
          r.err = 1'b1;
        end else begin
          case (ifn)
            4'd0: begin w = {b[63], b} + {a[63], a}; r.vale = w[63:0]; of = w[64] != w[63]; end
            4'd1: begin w = {b[63], b} - {a[63], a}; r.vale = w[63:0]; of = w[64] != w[63]; end
            4'd2: r.vale = a & b;
            default: r.vale = a ^ b;
          endcase
          r.cc = {r.vale == 64'd0, r.vale[63], of};
        end
      end
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  task automatic run_op(input logic [3:0] ic, input logic [3:0] ifn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        output res_t got);
    int waited;
    bus.icode    = ic;
    bus.ifun     = ifn;
    bus.val_a    = a;
    bus.val_b    = b;
    bus.val_c    = c;
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("exec_out_valid_low", 64'(bus.out_valid), 64'd0);
    tick();
    waited = 0;
    while (!bus.out_valid && waited < 20) begin
      tick();
      waited++;
    end
    check("done_out_valid_high", 64'(bus.out_valid), 64'd1);
    got.vale = bus.val_e;
    got.cnd  = bus.cnd;
    got.err  = bus.err;
    got.cc   = bus.cc;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  vec_t vecs[$];
  res_t got, exp_r;

  initial begin
    // Directed table; CC sequence starts from the reset value 3'b100.
    vecs.push_back('{4'h6, 4'd0, 64'd1, 64'd2, 64'd0, 64'd3, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{4'h6, 4'd1, 64'd5, 64'd5, 64'd0, 64'd0, 1'b1, 1'b0, 3'b100});
    vecs.push_back('{4'h7, 4'd3, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 3'b100});
    vecs.push_back('{4'h6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0,
                     64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 3'b011});
    vecs.push_back('{4'h7, 4'd2, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 3'b011});
    vecs.push_back('{4'h7, 4'd1, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 3'b011});
    vecs.push_back('{4'hA, 4'd0, 64'd0, 64'h100, 64'd0, 64'hF8, 1'b1, 1'b0, 3'b011});
    vecs.push_back('{4'hB, 4'd0, 64'd0, 64'hF8, 64'd0, 64'h100, 1'b1, 1'b0, 3'b011});
    vecs.push_back('{4'h6, 4'd7, 64'd9, 64'd4, 64'd0, 64'd0, 1'b1, 1'b1, 3'b011});
    vecs.push_back('{4'h2, 4'd7, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 3'b011});
    vecs.push_back('{4'h3, 4'd0, 64'd0, 64'd0, 64'h1234, 64'h1234, 1'b1, 1'b0, 3'b011});
    vecs.push_back('{4'h4, 4'd0, 64'd0, 64'h10, 64'h8, 64'h18, 1'b1, 1'b0, 3'b011});
    vecs.push_back('{4'hC, 4'd0, 64'd7, 64'd7, 64'd7, 64'd0, 1'b1, 1'b1, 3'b011});
    vecs.push_back('{4'h0, 4'd0, 64'd7, 64'd7, 64'd7, 64'd0, 1'b1, 1'b0, 3'b011});
    vecs.push_back('{4'h6, 4'd2, 64'hF0, 64'h3C, 64'd0, 64'h30, 1'b1, 1'b0, 3'b000});
    vecs.push_back('{4'h6, 4'd3, 64'hAA, 64'hAA, 64'd0, 64'd0, 1'b1, 1'b0, 3'b100});
    vecs.push_back('{4'h2, 4'd4, 64'h77, 64'd0, 64'd0, 64'h77, 1'b0, 1'b0, 3'b100});
    vecs.push_back('{4'h8, 4'd0, 64'd0, 64'h10, 64'd0, 64'h8, 1'b1, 1'b0, 3'b100});
    vecs.push_back('{4'h9, 4'd0, 64'd0, 64'h8, 64'd0, 64'h10, 1'b1, 1'b0, 3'b100});
    vecs.push_back('{4'h6, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'd0,
                     64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 3'b001});
    vecs.push_back('{4'h7, 4'd6, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 3'b001});
    vecs.push_back('{4'h7, 4'd4, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 3'b001});

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.icode     = 4'h0;
    bus.ifun      = 4'h0;
    bus.val_a     = 64'd0;
    bus.val_b     = 64'd0;
    bus.val_c     = 64'd0;
    tick();
    tick();
    check("reset_cc", 64'(bus.cc), 64'h4);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_val_e", bus.val_e, 64'd0);
    check("reset_cnd_err", 64'({bus.cnd, bus.err}), 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].icode, vecs[i].ifun, vecs[i].a, vecs[i].b, vecs[i].c, got);
      check($sformatf("vec%0d_val_e", i), got.vale, vecs[i].vale);
      check($sformatf("vec%0d_cnd", i), 64'(got.cnd), 64'(vecs[i].cnd));
      check($sformatf("vec%0d_err", i), 64'(got.err), 64'(vecs[i].err));
      check($sformatf("vec%0d_cc", i), 64'(got.cc), 64'(vecs[i].cc));
    end
    model_cc = vecs[vecs.size()-1].cc;

    // Back-pressure: DONE held 5 cycles with in_valid asserted must not accept.
    bus.icode = 4'h6; bus.ifun = 4'd0;
    bus.val_a = 64'd10; bus.val_b = 64'd20; bus.val_c = 64'd0;
    bus.in_valid = 1'b1;
    tick();
    bus.val_a = 64'd99; bus.val_b = 64'd1;
    check("stall_exec_out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("stall_val_e", bus.val_e, 64'd30);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    check("release_out_valid", 64'(bus.out_valid), 64'd0);
    tick();
    check("release_no_accept", 64'(bus.in_ready), 64'd1);
    check("stall_cc", 64'(bus.cc), 64'h0);
    model_cc = 3'b000;

    // Reset while in EXEC: result discarded, CC back to its reset value.
    bus.icode = 4'h6; bus.ifun = 4'd0;
    bus.val_a = 64'd1; bus.val_b = 64'd1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_exec_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_exec_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_exec_cc", 64'(bus.cc), 64'h4);
    check("rst_exec_val_e", bus.val_e, 64'd0);
    tick();
    check("rst_exec_discarded", 64'(bus.out_valid), 64'd0);
    model_cc = 3'b100;

    for (int n = 0; n < 300; n++) begin
      logic [3:0]  ic, ifn;
      logic [63:0] a, b, c;
      ic  = 4'($urandom_range(0, 15));
      ifn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      if (ic == 4'h6 && $urandom_range(0, 1) == 1) ifn = 4'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      c = {$urandom, $urandom};
      exp_r = model(ic, ifn, a, b, c, model_cc);
      run_op(ic, ifn, a, b, c, got);
      check($sformatf("rnd%0d_ic%h_f%h_val_e", n, ic, ifn), got.vale, exp_r.vale);
      check($sformatf("rnd%0d_ic%h_f%h_cnd", n, ic, ifn), 64'(got.cnd), 64'(exp_r.cnd));
      check($sformatf("rnd%0d_ic%h_f%h_err", n, ic, ifn), 64'(got.err), 64'(exp_r.err));
      check($sformatf("rnd%0d_ic%h_f%h_cc", n, ic, ifn), 64'(got.cc), 64'(exp_r.cc));
      model_cc = exp_r.cc;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
